// File: rtl/dco_multimode_pkg.sv
// -----------------------------------------------------------------------------
// dco_pkg
// Shared definitions for the multimode digitally-controlled oscillator:
//   - dco_state_e : oscillator control states (IDLE, RUN, DRAIN)
//   - MODE_PRIO / MODE_LIN : code-mapping mode encodings
//   - sat_add     : saturating add used by the half-period mapping
// -----------------------------------------------------------------------------
package dco_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dco_state_e;

    localparam logic MODE_PRIO = 1'b0;
    localparam logic MODE_LIN  = 1'b1;

    // a + b clipped to max_v. A 33-bit sum keeps the carry so that large
    // operands cannot wrap before the comparison.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max_v}) ? max_v : s[31:0];
    endfunction

endpackage

// File: rtl/dco_multimode_if.sv
// -----------------------------------------------------------------------------
// dco_multimode_if
// Code-load handshake between the control registers and the oscillator.
//   code_valid : source offers a new code (held until accepted)
//   code_ready : oscillator can accept a code (low while one is pending)
//   code       : control code, CODE_W bits
//   mode       : 0 = priority mapping, 1 = linear mapping
// master = code source, slave = oscillator.
// -----------------------------------------------------------------------------
interface dco_multimode_if #(
    parameter int CODE_W = 8
) ();
    logic              code_valid;
    logic              code_ready;
    logic [CODE_W-1:0] code;
    logic              mode;

    modport master (output code_valid, output code, output mode, input  code_ready);
    modport slave  (input  code_valid, input  code, input  mode, output code_ready);
endinterface

// File: rtl/dco_multimode_code_map.sv
// -----------------------------------------------------------------------------
// dco_code_map
// Combinational mapping from a control code to a half-period in clk cycles.
//   i_code : control code
//   i_mode : MODE_PRIO -> MIN_HP + index of highest set bit (ZERO_HP for 0)
//            MODE_LIN  -> MIN_HP + code
//   o_hp   : half-period, saturated to 2^CNT_W-1
// -----------------------------------------------------------------------------
module dco_code_map
    import dco_pkg::*;
#(
    parameter int unsigned CODE_W  = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned MIN_HP  = 3,
    parameter int unsigned ZERO_HP = 50
) (
    input  logic [CODE_W-1:0] i_code,
    input  logic              i_mode,
    output logic [CNT_W-1:0]  o_hp
);
    localparam logic [31:0] HP_MAX = (32'd1 << CNT_W) - 32'd1;

    logic [31:0] w_msb;
    logic [31:0] w_hp_full;

    always_comb begin
        // Ascending scan: the last set bit seen is the most significant one.
        w_msb = 32'd0;
        for (int i = 0; i < int'(CODE_W); i++) begin
            if (i_code[i]) w_msb = i[31:0];
        end

        if (i_mode == MODE_LIN) begin
            w_hp_full = sat_add(MIN_HP, 32'(i_code), HP_MAX);
        end else if (i_code == '0) begin
            w_hp_full = sat_add(ZERO_HP, 32'd0, HP_MAX);
        end else begin
            w_hp_full = sat_add(MIN_HP, w_msb, HP_MAX);
        end
    end

    assign o_hp = w_hp_full[CNT_W-1:0];

endmodule

// File: rtl/dco_multimode.sv
// -----------------------------------------------------------------------------
// dco_multimode
// Digitally-controlled oscillator: square wave with a half-period of
// hp_active clk cycles. New codes arrive over a valid/ready handshake and are
// applied only at a half-period boundary, so the output never glitches.
// Dropping ena stops the output cleanly: a high phase is allowed to finish
// (DRAIN) before parking low in IDLE.
//   clk      : system clock
//   resetn   : asynchronous, active-low reset
//   ena      : oscillator enable
//   ctrl     : code-load handshake (slave side)
//   dco_out  : oscillator output, registered
//   running  : high in RUN and DRAIN
//   applied  : one-cycle pulse when a pending code becomes active
// -----------------------------------------------------------------------------
module dco_multimode
    import dco_pkg::*;
#(
    parameter int unsigned CODE_W   = 8,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned MIN_HP   = 3,
    parameter int unsigned ZERO_HP  = 50,
    parameter int unsigned RESET_HP = 50
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ena,
    dco_multimode_if.slave     ctrl,
    output logic               dco_out,
    output logic               running,
    output logic               applied
);
    dco_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hp_active;
    logic [CNT_W-1:0] r_pend_hp;
    logic             r_pending;
    logic             r_dco;
    logic             r_running;
    logic             r_applied;

    logic [CNT_W-1:0] w_map_hp;
    logic             w_accept;
    logic             w_term;
    logic             w_dco_nxt;

    dco_code_map #(
        .CODE_W  (CODE_W),
        .CNT_W   (CNT_W),
        .MIN_HP  (MIN_HP),
        .ZERO_HP (ZERO_HP)
    ) u_code_map (
        .i_code (ctrl.code),
        .i_mode (ctrl.mode),
        .o_hp   (w_map_hp)
    );

    assign w_accept  = ctrl.code_valid & ~r_pending;
    // >= rather than == so a shrinking hp_active can never strand the counter.
    assign w_term    = (r_cnt >= (r_hp_active - CNT_W'(1)));
    // The stop decision looks at the output as it will be after this edge.
    assign w_dco_nxt = r_dco ^ w_term;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hp_active <= CNT_W'(RESET_HP);
            r_pend_hp   <= '0;
            r_pending   <= 1'b0;
            r_dco       <= 1'b0;
            r_running   <= 1'b0;
            r_applied   <= 1'b0;
        end else begin
            r_applied <= 1'b0;

            if (w_accept) begin
                r_pend_hp <= w_map_hp;
                r_pending <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    r_dco <= 1'b0;
                    if (ena) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                        if (r_pending) begin
                            r_hp_active <= r_pend_hp;
                            r_pending   <= 1'b0;
                            r_applied   <= 1'b1;
                        end
                    end
                end

                RUN, DRAIN: begin
                    if (w_term) begin
                        r_cnt <= '0;
                        r_dco <= ~r_dco;
                        if (r_pending) begin
                            r_hp_active <= r_pend_hp;
                            r_pending   <= 1'b0;
                            r_applied   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end

                    // Re-enabling from DRAIN resumes with count and output intact.
                    if (ena) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end else if (w_dco_nxt) begin
                        r_state   <= DRAIN;
                        r_running <= 1'b1;
                    end else begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                        r_cnt     <= '0;
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl.code_ready = ~r_pending;
    assign dco_out         = r_dco;
    assign running         = r_running;
    assign applied         = r_applied;

endmodule

// File: tb/tb_dco_multimode.sv
module tb_dco_multimode;
    import dco_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    logic ena;
    logic dco_out;
    logic running;
    logic applied;

    dco_multimode_if #(.CODE_W(8)) cif ();

    dco_multimode #(
        .CODE_W   (8),
        .CNT_W    (8),
        .MIN_HP   (3),
        .ZERO_HP  (50),
        .RESET_HP (50)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .ena     (ena),
        .ctrl    (cif),
        .dco_out (dco_out),
        .running (running),
        .applied (applied)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    typedef struct {
        logic       mode;
        logic [7:0] code;
        int         exp_hp;
        string      name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a code for one cycle (caller guarantees code_ready is high) and
    // record the half-period it should produce.
    task automatic send(input string name, input logic m, input logic [7:0] c, input int exp);
        cif.mode       = m;
        cif.code       = c;
        cif.code_valid = 1'b1;
        tick();
        cif.code_valid = 1'b0;
        exp_q.push_back(exp);
        check({name, "_ready_low"}, int'(cif.code_ready), 0);
    endtask

    task automatic wait_applied(input string name, output int ncyc, output bit ok);
        ncyc = 0;
        ok   = 1'b0;
        while (ncyc < 1000 && !ok) begin
            tick();
            ncyc++;
            if (applied) ok = 1'b1;
        end
        if (!ok) check({name, "_applied_timeout"}, 0, 1);
    endtask

    // Cycles until dco_out next changes; -1 if it never does.
    task automatic next_toggle(output int n);
        logic last;
        bit   seen;
        last = dco_out;
        seen = 1'b0;
        n    = 0;
        while (n < 600 && !seen) begin
            tick();
            n++;
            if (dco_out != last) seen = 1'b1;
        end
        if (!seen) n = -1;
    endtask

    // Leaves the bench observing the cycle right after a rising edge of dco_out.
    task automatic align_rise();
        int n;
        next_toggle(n);
        if (dco_out == 1'b0) next_toggle(n);
        check("align_rise_found", int'(dco_out), 1);
    endtask

    task automatic pop_exp(input string name, output int e);
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 0, 1);
            e = -1;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    initial begin
        int  n, h1, h2, e, ncyc, ready_hi, nrun, k;
        bit  ok, fell;

        vecs[0] = '{MODE_PRIO, 8'b0000_0001,   3, "prio_bit0"};
        vecs[1] = '{MODE_PRIO, 8'b1000_0000,  10, "prio_bit7"};
        vecs[2] = '{MODE_PRIO, 8'b0000_0000,  50, "prio_zero"};
        vecs[3] = '{MODE_LIN,  8'd20,         23, "lin_20"};
        vecs[4] = '{MODE_LIN,  8'd255,       255, "lin_255_sat"};
        vecs[5] = '{MODE_PRIO, 8'b0010_1100,   8, "prio_multi"};
        vecs[6] = '{MODE_LIN,  8'd252,       255, "lin_252_edge"};
        vecs[7] = '{MODE_LIN,  8'd0,           3, "lin_0"};

        resetn         = 1'b0;
        ena            = 1'b0;
        cif.code_valid = 1'b0;
        cif.code       = '0;
        cif.mode       = 1'b0;
        tick();
        tick();
        check("rst_dco_out", int'(dco_out), 0);
        check("rst_running", int'(running), 0);
        check("rst_applied", int'(applied), 0);
        check("rst_code_ready", int'(cif.code_ready), 1);
        resetn = 1'b1;
        tick();
        check("idle_dco_out", int'(dco_out), 0);

        // Free-running at the reset half-period.
        ena = 1'b1;
        tick();
        check("run_running", int'(running), 1);
        next_toggle(n);
        check("first_rise_delay", n, 50);
        next_toggle(h1);
        check("reset_hp", h1, 50);

        // Table of code loads.
        for (int v = 0; v < 8; v++) begin
            send(vecs[v].name, vecs[v].mode, vecs[v].code, vecs[v].exp_hp);
            wait_applied(vecs[v].name, ncyc, ok);
            if (ok) begin
                check({vecs[v].name, "_ready_after_apply"}, int'(cif.code_ready), 1);
                pop_exp(vecs[v].name, e);
                next_toggle(h1);
                check({vecs[v].name, "_hp_first"}, h1, e);
                next_toggle(h2);
                check({vecs[v].name, "_hp_second"}, h2, e);
            end
        end

        // Mid-half-period load, with a second offer ignored while pending.
        send("mid_base", MODE_PRIO, 8'b0000_0000, 50);
        wait_applied("mid_base", ncyc, ok);
        pop_exp("mid_base", e);
        for (int i = 0; i < 20; i++) tick();
        send("mid_load", MODE_PRIO, 8'b0001_0000, 7);
        cif.mode       = MODE_LIN;
        cif.code       = 8'd100;
        cif.code_valid = 1'b1;
        ready_hi = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cif.code_ready) ready_hi++;
        end
        cif.code_valid = 1'b0;
        check("mid_ready_held_low", ready_hi, 0);
        wait_applied("mid_load", ncyc, ok);
        check("mid_apply_delay", ncyc + 5, 29);
        pop_exp("mid_load", e);
        next_toggle(h1);
        check("mid_hp_first", h1, e);
        next_toggle(h2);
        check("mid_hp_second", h2, e);
        check("mid_queue_drained", exp_q.size(), 0);

        // Clean stop from the high phase: hp 10, ena drops at counter 2.
        send("drain_load", MODE_PRIO, 8'b1000_0000, 10);
        wait_applied("drain_load", ncyc, ok);
        pop_exp("drain_load", e);
        align_rise();
        tick();
        tick();
        ena  = 1'b0;
        k    = 0;
        nrun = 0;
        fell = 1'b0;
        while (k < 30 && !fell) begin
            tick();
            k++;
            if (dco_out == 1'b0) fell = 1'b1;
            else if (running) nrun++;
        end
        check("drain_running_cycles", nrun, 7);
        check("drain_fall_tick", k, 8);
        check("drain_idle_running", int'(running), 0);
        tick();
        check("drain_idle_dco", int'(dco_out), 0);

        // Stop from the low phase: IDLE on the next cycle.
        ena = 1'b1;
        tick();
        check("restart_running", int'(running), 1);
        tick();
        tick();
        ena = 1'b0;
        tick();
        check("low_stop_running", int'(running), 0);
        check("low_stop_dco", int'(dco_out), 0);

        // Re-enable during DRAIN: high phase keeps its full length.
        ena = 1'b1;
        tick();
        align_rise();
        tick();
        tick();
        ena = 1'b0;
        tick();
        check("reen_in_drain_running", int'(running), 1);
        check("reen_in_drain_dco", int'(dco_out), 1);
        tick();
        ena = 1'b1;
        next_toggle(n);
        check("reen_high_remaining", n, 6);
        next_toggle(n);
        check("reen_low_phase", n, 10);
        check("reen_running", int'(running), 1);

        // Asynchronous reset in the middle of a high phase.
        align_rise();
        tick();
        tick();
        tick();
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_dco", int'(dco_out), 0);
        check("async_rst_running", int'(running), 0);
        check("async_rst_ready", int'(cif.code_ready), 1);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        next_toggle(n);
        next_toggle(h1);
        check("post_reset_hp", h1, 50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
